// File: rtl/struct_pckg.sv
// Shared pipeline types: the EX->MEM->WB bundle, memory width encodings,
// the memory-stage state enum and small helpers shared by the stage and
// its load-alignment sub-block.
package struct_pckg;

  typedef struct packed {
    logic        is_valid;
    logic [63:0] pc;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ext;
    logic [3:0]  mem_req_unit;
    logic [7:0]  mem_wr_en;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic        rf_wr;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
  } interconnection_struct;

  // One-hot access widths carried in mem_req_unit.
  localparam logic [3:0] MEM_UNIT_B = 4'b0001;
  localparam logic [3:0] MEM_UNIT_H = 4'b0010;
  localparam logic [3:0] MEM_UNIT_W = 4'b0100;
  localparam logic [3:0] MEM_UNIT_D = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DRAIN  = 2'd3
  } mem_state_e;

  // Byte-lane mask of an access at offset 0.
  function automatic logic [7:0] unit_mask(input logic [3:0] unit);
    case (unit)
      MEM_UNIT_B: unit_mask = 8'h01;
      MEM_UNIT_H: unit_mask = 8'h03;
      MEM_UNIT_W: unit_mask = 8'h0F;
      default:    unit_mask = 8'hFF;
    endcase
  endfunction

  // An access must sit on a boundary of its own size.
  function automatic logic is_misaligned(input logic [3:0] unit, input logic [2:0] off);
    case (unit)
      MEM_UNIT_B: is_misaligned = 1'b0;
      MEM_UNIT_H: is_misaligned = off[0];
      MEM_UNIT_W: is_misaligned = |off[1:0];
      default:    is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load-data alignment: moves the addressed lanes down to bit 0, trims to
// the access width and sign- or zero-extends to 64 bits. Combinational so
// it can also sit on a store-forwarding path.
module load_align
  import struct_pckg::*;
(
  input  logic [63:0] i_rdata,
  input  logic [2:0]  i_off,
  input  logic [3:0]  i_unit,
  input  logic        i_ext,
  output logic [63:0] o_data
);

  logic [63:0] w_shifted;

  // Shift to lane 0, then trim and extend according to the access width.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    w_shifted = i_rdata >> {i_off, 3'b000};
    o_data    = w_shifted;
    case (i_unit)
      MEM_UNIT_B: o_data = {{56{i_ext & w_shifted[7]}},  w_shifted[7:0]};
      MEM_UNIT_H: o_data = {{48{i_ext & w_shifted[15]}}, w_shifted[15:0]};
      MEM_UNIT_W: o_data = {{32{i_ext & w_shifted[31]}}, w_shifted[31:0]};
      default:    o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Takes the EX bundle, runs one load or store
// on the data-memory req/gnt/rvalid port, aligns load data into rf_wr_data
// and hands the bundle to WB. EX is stalled (mem_ready_o=0) whenever a
// transaction is in flight.
module mem_access_stage
  import struct_pckg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  interconnection_struct ex_mem_i,
  output logic                  mem_ready_o,
  input  logic                  flush_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [7:0]            dm_be_o,
  output logic [ADDR_W-1:0]     dm_addr_o,
  output logic [DATA_W-1:0]     dm_wdata_o,
  input  logic                  dm_gnt_i,
  input  logic                  dm_rvalid_i,
  input  logic [DATA_W-1:0]     dm_rdata_i,
  output interconnection_struct mem_wb_o,
  output logic                  misalign_o
);

  mem_state_e            r_state;
  interconnection_struct r_op;
  interconnection_struct r_wb;
  logic                  r_misalign;
  logic                  r_req;
  logic                  r_we;
  logic [7:0]            r_be;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;

  logic [2:0]            w_in_off;
  logic                  w_in_mem;
  logic                  w_accept;
  logic [7:0]            w_be;
  logic [DATA_W-1:0]     w_wdata;
  logic [63:0]           w_load_data;

  // Request fields of the incoming bundle: byte lanes and data moved to the
  // addressed offset.
  assign w_in_off = ex_mem_i.mem_addr[2:0];
  assign w_in_mem = ex_mem_i.mem_rd | ex_mem_i.mem_wr;
  assign w_accept = ex_mem_i.is_valid & ~flush_i;
  assign w_be     = unit_mask(ex_mem_i.mem_req_unit) << w_in_off;
  assign w_wdata  = ex_mem_i.mem_data << {w_in_off, 3'b000};

  load_align u_load_align (
    .i_rdata (dm_rdata_i),
    .i_off   (r_op.mem_addr[2:0]),
    .i_unit  (r_op.mem_req_unit),
    .i_ext   (r_op.mem_ext),
    .o_data  (w_load_data)
  );

  // Transaction FSM; all memory-port and WB outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_wb       <= '0;
      r_misalign <= 1'b0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values; a later assignment to the same field
      // in this block (e.g. is_valid below) simply overrides the default.
      r_wb.is_valid <= 1'b0;
      r_misalign    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_in_mem) begin
              r_wb <= ex_mem_i;
            end else if (is_misaligned(ex_mem_i.mem_req_unit, w_in_off)) begin
              // Dropped access still retires so the pipeline stays in order,
              // but it must not write the register file.
              r_wb       <= ex_mem_i;
              r_wb.rf_wr <= 1'b0;
              r_misalign <= 1'b1;
            end else begin
              r_op    <= ex_mem_i;
              r_req   <= 1'b1;
              r_we    <= ex_mem_i.mem_wr;
              r_be    <= w_be;
              r_addr  <= ex_mem_i.mem_addr[ADDR_W-1:0];
              r_wdata <= w_wdata;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (dm_gnt_i) begin
            r_req <= 1'b0;
            if (flush_i) begin
              // A granted load still owes a data beat that must be absorbed.
              r_state <= r_we ? IDLE : DRAIN;
            end else if (r_we) begin
              r_wb    <= r_op;
              r_state <= IDLE;
            end else begin
              r_state <= WAIT_R;
            end
          end else if (flush_i) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        WAIT_R: begin
          if (flush_i) begin
            r_state <= dm_rvalid_i ? IDLE : DRAIN;
          end else if (dm_rvalid_i) begin
            r_wb            <= r_op;
            r_wb.rf_wr_data <= w_load_data;
            r_state         <= IDLE;
          end
        end
        DRAIN: begin
          if (dm_rvalid_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_ready_o = (r_state == IDLE);
  assign dm_req_o    = r_req;
  assign dm_we_o     = r_we;
  assign dm_be_o     = r_be;
  assign dm_addr_o   = r_addr;
  assign dm_wdata_o  = r_wdata;
  assign mem_wb_o    = r_wb;
  assign misalign_o  = r_misalign;

endmodule
